bj_game_ctrl: RTL and testbench

- Sequencer for the BJkernel datapath. Runs a match of N blackjack games: issues NewGame, answers each NextCard request with a card pulled from a deck source over a valid/ready handshake, and presents it on Card/NewCard.
- Classifies each game end (OK = win, Fail = loss) and keeps match statistics.
- Sits between the deck source and BJkernel, in place of BJsource, on the BJ_clock domain.

---
 rtl/bj_game_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bj_game_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bj_game_ctrl.sv
// rtl/bj_game_ctrl.sv - blackjack match sequencer between a deck source and BJkernel.
// Optional macro BJ_CARD_CHECK_EN: discard cards outside 1..10 and count them on bad_cards.
module bj_game_ctrl #(
    parameter int NEWGAME_CYCLES = 2,
    parameter int TIMEOUT        = 64,
    parameter int CNT_W          = 8
) (
    input  logic             BJ_clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_games,
    input  logic             card_valid,
    input  logic [3:0]       card_in,
    output logic             card_ready,
    input  logic             NextCard,
    input  logic             OK,
    input  logic             Fail,
    output logic             NewGame,
    output logic             NewCard,
    output logic [3:0]       Card,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses,
    output logic [CNT_W-1:0] games_played,
`ifdef BJ_CARD_CHECK_EN
    output logic [CNT_W-1:0] bad_cards,
`endif
    output logic             timeout_err
);

    typedef enum logic [3:0] {
        IDLE, NEWG, WAIT_REQ, FETCH, DEAL, DROP, ENDG, DONE, ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       NG_LAST   = 4'(NEWGAME_CYCLES);
    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [3:0]       ng_cnt;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] games_inc;
    logic             card_good;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        games_inc = sat_inc(games_played);
`ifdef BJ_CARD_CHECK_EN
        card_good = (card_in != 4'd0) && (card_in <= 4'd10);
`else
        card_good = 1'b1;
`endif
    end

    always_ff @(posedge BJ_clock) begin
        if (reset) begin
            state        <= IDLE;
            num_lat      <= '0;
            ng_cnt       <= '0;
            wait_cnt     <= '0;
            card_ready   <= 1'b0;
            NewGame      <= 1'b0;
            NewCard      <= 1'b0;
            Card         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wins         <= '0;
            losses       <= '0;
            games_played <= '0;
            timeout_err  <= 1'b0;
`ifdef BJ_CARD_CHECK_EN
            bad_cards    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat      <= num_games;
                        wins         <= '0;
                        losses       <= '0;
                        games_played <= '0;
                        timeout_err  <= 1'b0;
`ifdef BJ_CARD_CHECK_EN
                        bad_cards    <= '0;
`endif
                        busy         <= 1'b1;
                        if (num_games == '0) begin
                            state <= DONE;
                        end else begin
                            state   <= NEWG;
                            NewGame <= 1'b1;
                            ng_cnt  <= 4'd1;
                        end
                    end
                end
                NEWG: begin
                    if (ng_cnt == NG_LAST) begin
                        NewGame  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT_REQ;
                    end else begin
                        ng_cnt <= ng_cnt + 4'd1;
                    end
                end
                WAIT_REQ: begin
                    // Fail outranks OK so a simultaneous report scores as a loss
                    if (Fail) begin
                        losses <= sat_inc(losses);
                        state  <= ENDG;
                    end else if (OK) begin
                        wins  <= sat_inc(wins);
                        state <= ENDG;
                    end else if (NextCard) begin
                        card_ready <= 1'b1;
                        state      <= FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FETCH: begin
                    if (card_valid && card_ready) begin
                        if (card_good) begin
                            Card       <= card_in;
                            card_ready <= 1'b0;
                            NewCard    <= 1'b1;
                            state      <= DEAL;
                        end
`ifdef BJ_CARD_CHECK_EN
                        else begin
                            bad_cards <= sat_inc(bad_cards);
                        end
`endif
                    end
                end
                DEAL: begin
                    NewCard  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= DROP;
                end
                DROP: begin
                    if (!NextCard) begin
                        wait_cnt <= '0;
                        state    <= WAIT_REQ;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ENDG: begin
                    games_played <= games_inc;
                    if (games_inc == num_lat) begin
                        state <= DONE;
                    end else begin
                        NewGame <= 1'b1;
                        ng_cnt  <= 4'd1;
                        state   <= NEWG;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bj_game_ctrl.sv
// tb/tb_bj_game_ctrl.sv - self-checking bench for bj_game_ctrl.
module tb_bj_game_ctrl;

    logic       BJ_clock = 1'b0;
    logic       reset, start, card_valid, NextCard, OK, Fail;
    logic [7:0] num_games;
    logic [3:0] card_in;
    logic       card_ready, NewGame, NewCard, busy, done, timeout_err;
    logic [3:0] Card;
    logic [7:0] wins, losses, games_played;
`ifdef BJ_CARD_CHECK_EN
    logic [7:0] bad_cards;
`endif

    bj_game_ctrl dut (
        .BJ_clock(BJ_clock), .reset(reset), .start(start), .num_games(num_games),
        .card_valid(card_valid), .card_in(card_in), .card_ready(card_ready),
        .NextCard(NextCard), .OK(OK), .Fail(Fail), .NewGame(NewGame),
        .NewCard(NewCard), .Card(Card), .busy(busy), .done(done),
        .wins(wins), .losses(losses), .games_played(games_played),
`ifdef BJ_CARD_CHECK_EN
        .bad_cards(bad_cards),
`endif
        .timeout_err(timeout_err)
    );

    always #5 BJ_clock = ~BJ_clock;

    int total = 0;
    int bad   = 0;

    int   ng_cycles = 0, ng_pulses = 0, nc_pulses = 0, done_pulses = 0;
    logic ng_prev = 1'b0;

    always @(negedge BJ_clock) begin
        ng_prev     <= NewGame;
        ng_cycles   <= ng_cycles + int'(NewGame);
        ng_pulses   <= ng_pulses + int'(NewGame && !ng_prev);
        nc_pulses   <= nc_pulses + int'(NewCard);
        done_pulses <= done_pulses + int'(done);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge BJ_clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start     = 1'b1;
        num_games = n;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_newgame_end(input string tag);
        bit saw = 1'b0, ended = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            if (NewGame) saw = 1'b1;
            else if (saw) ended = 1'b1;
            if (!ended) step();
        end
        chk({tag, ".newgame_end"}, 32'(ended), 1);
    endtask

    task automatic deal_card(input string tag, input logic [3:0] c, input int stall);
        NextCard = 1'b1;
        step();
        chk({tag, ".ready"}, 32'(card_ready), 1);
        card_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            if (i == stall - 1) begin
                chk({tag, ".stall_ready"}, 32'(card_ready), 1);
                chk({tag, ".stall_nocard"}, 32'(NewCard), 0);
            end
        end
        card_valid = 1'b1;
        card_in    = c;
        step();
        chk({tag, ".newcard"}, 32'(NewCard), 1);
        chk({tag, ".card"}, 32'(Card), 32'(c));
        card_valid = 1'b0;
        NextCard   = 1'b0;
        step();
        step();
    endtask

    task automatic finish_game(input int res);
        OK   = res[0] && !res[1] ? 1'b1 : res[0];
        Fail = res[1];
        step();
        OK   = 1'b0;
        Fail = 1'b0;
        step();
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk({tag, ".done_seen"}, 32'(seen), 1);
        step();
    endtask

    // Reference: results are tallied per game; a game with Fail is a loss regardless of OK.
    task automatic run_match(input string tag, input int n, input int res_q[$],
                             input int ncard_q[$], input int card_q[$]);
        int exp_w = 0, exp_l = 0, cards = 0, ci = 0;
        int ng0 = ng_pulses, ngc0 = ng_cycles, nc0 = nc_pulses, d0 = done_pulses;
        do_start(8'(n));
        chk({tag, ".err_clr"}, 32'(timeout_err), 0);
        chk({tag, ".first_ng"}, 32'(NewGame), 1);
        for (int g = 0; g < n; g++) begin
            int k, res;
            wait_newgame_end(tag);
            k = (g < ncard_q.size()) ? ncard_q[g] : int'($urandom_range(0, 2));
            for (int j = 0; j < k; j++) begin
                int c;
                c = (ci < card_q.size()) ? card_q[ci] : int'($urandom_range(1, 10));
                ci++;
                deal_card(tag, 4'(c), int'($urandom_range(0, 3)));
                cards++;
            end
            res = (g < res_q.size()) ? res_q[g] : int'($urandom_range(1, 3));
            if (res >= 2) exp_l = (exp_l < 255) ? exp_l + 1 : 255;
            else          exp_w = (exp_w < 255) ? exp_w + 1 : 255;
            finish_game(res);
        end
        wait_done(tag);
        chk({tag, ".wins"}, 32'(wins), 32'(exp_w));
        chk({tag, ".losses"}, 32'(losses), 32'(exp_l));
        chk({tag, ".played"}, 32'(games_played), 32'(n));
        chk({tag, ".ng_pulses"}, 32'(ng_pulses - ng0), 32'(n));
        chk({tag, ".ng_cycles"}, 32'(ng_cycles - ngc0), 32'(2 * n));
        chk({tag, ".nc_pulses"}, 32'(nc_pulses - nc0), 32'(cards));
        chk({tag, ".done_pulses"}, 32'(done_pulses - d0), 1);
        chk({tag, ".busy"}, 32'(busy), 0);
`ifdef BJ_CARD_CHECK_EN
        chk({tag, ".bad_cards"}, 32'(bad_cards), 0);
`endif
    endtask

    initial begin
        int none[$];
        int r1[$], k1[$], c1[$], r3[$];
        int d0, nc0, ng0;
        reset = 1'b1; start = 1'b0; card_valid = 1'b0; NextCard = 1'b0;
        OK = 1'b0; Fail = 1'b0; num_games = '0; card_in = '0;
        repeat (3) step();
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ng", 32'(NewGame), 0);
        chk("rst.nc", 32'(NewCard), 0);
        chk("rst.card", 32'(Card), 0);
        chk("rst.ready", 32'(card_ready), 0);
        chk("rst.counters", {8'(wins), 8'(losses), 8'(games_played), 8'(timeout_err)}, 0);
        reset = 1'b0;
        step();

        r1 = '{1}; k1 = '{1}; c1 = '{7};
        run_match("single", 1, r1, k1, c1);
        chk("single.card_hold", 32'(Card), 7);

        r3 = '{2, 1, 3};
        run_match("three", 3, r3, none, none);

        d0 = done_pulses; ng0 = ng_pulses;
        do_start(8'd0);
        chk("zero.done_early", 32'(done), 0);
        chk("zero.busy", 32'(busy), 1);
        step();
        chk("zero.done", 32'(done), 1);
        chk("zero.counters", {8'(wins), 8'(losses), 8'(games_played)}, 0);
        step();
        step();
        chk("zero.busy_after", 32'(busy), 0);
        chk("zero.no_newgame", 32'(ng_pulses - ng0), 0);
        chk("zero.done_once", 32'(done_pulses - d0), 1);

        d0 = done_pulses;
        do_start(8'd1);
        wait_newgame_end("tmo");
        NextCard = 1'b1;
        step();
        card_valid = 1'b1; card_in = 4'd3;
        step();
        card_valid = 1'b0;
        repeat (56) step();
        chk("tmo.busy_before", 32'(busy), 1);
        chk("tmo.err_before", 32'(timeout_err), 0);
        repeat (20) step();
        chk("tmo.err", 32'(timeout_err), 1);
        chk("tmo.idle", 32'(busy), 0);
        chk("tmo.no_done", 32'(done_pulses - d0), 0);
        NextCard = 1'b0;
        step();
        run_match("after_tmo", 2, none, none, none);

        do_start(8'd1);
        wait_newgame_end("stall");
        deal_card("stall", 4'd5, 80);
        chk("stall.no_err", 32'(timeout_err), 0);
        finish_game(1);
        wait_done("stall");
        chk("stall.wins", 32'(wins), 1);

`ifdef BJ_CARD_CHECK_EN
        nc0 = nc_pulses;
        do_start(8'd1);
        wait_newgame_end("chk");
        NextCard = 1'b1;
        step();
        card_valid = 1'b1; card_in = 4'd0;
        step();
        chk("chk.ready0", 32'(card_ready), 1);
        chk("chk.nc0", 32'(NewCard), 0);
        card_in = 4'd12;
        step();
        chk("chk.bad2", 32'(bad_cards), 2);
        card_in = 4'd4;
        step();
        chk("chk.nc", 32'(NewCard), 1);
        chk("chk.card", 32'(Card), 4);
        card_valid = 1'b0; NextCard = 1'b0;
        step(); step();
        finish_game(1);
        wait_done("chk");
        chk("chk.one_nc", 32'(nc_pulses - nc0), 1);
        chk("chk.bad_final", 32'(bad_cards), 2);
`endif

        for (int m = 0; m < 4; m++)
            run_match("rand", int'($urandom_range(1, 5)), none, none, none);
        run_match("full", 255, none, none, none);

        d0 = done_pulses;
        do_start(8'd2);
        wait_newgame_end("rst");
        finish_game(1);
        wait_newgame_end("rst");
        NextCard = 1'b1;
        step();
        card_valid = 1'b1; card_in = 4'd9;
        step();
        chk("rst_deal.in_deal", 32'(NewCard), 1);
        chk("rst_deal.wins_pre", 32'(wins), 1);
        reset = 1'b1; card_valid = 1'b0; NextCard = 1'b0;
        step();
        chk("rst_deal.nc", 32'(NewCard), 0);
        chk("rst_deal.card", 32'(Card), 0);
        chk("rst_deal.counters", {8'(wins), 8'(losses), 8'(games_played), 8'(busy)}, 0);
        reset = 1'b0;
        repeat (6) step();
        chk("rst_deal.no_done", 32'(done_pulses - d0), 0);
        chk("rst_deal.idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
